// File: rtl/adc_2308_responder.sv
// SPI target emulating an 8-channel, 12-bit ADC: accepts a 6-bit config word,
// returns the sample selected by the previous frame, then models conversion time.
module adc_2308_responder #(
    parameter int CONV_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adc_cs_n,
    input  logic        adc_sclk,
    input  logic        adc_din,
    output logic        adc_dout,
    input  logic [95:0] ch_data,
    output logic [5:0]  cfg_word,
    output logic        frame_done,
    output logic        protocol_error,
    output logic        busy
);

    localparam int         CNT_W      = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [5:0] CFG_RESET  = 6'b100010;
    localparam logic [1:0] FLUSH_DONE = 2'(SYNC_STAGES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CONVERT
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;
    logic [1:0]             r_flush_cnt;
    logic                   r_armed;

    state_t                 r_state;
    logic                   r_dout;
    logic [5:0]             r_cfg;
    logic [5:0]             r_cfg_sh;
    logic [11:0]            r_result;
    logic [10:0]            r_tx;
    logic [3:0]             r_bit_cnt;
    logic [CNT_W-1:0]       r_conv_cnt;
    logic                   r_busy;
    logic                   r_frame_done;
    logic                   r_perr;

    logic                   w_cs_s;
    logic                   w_sclk_s;
    logic                   w_din_s;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cfg_ok;
    logic [2:0]             w_ch_sel;
    logic [11:0]            w_ch [8];

    // NOTE: non-blocking assignments make each stage take the previous stage's old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_din_sync  <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], adc_sclk};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], adc_din};
            r_cs_prev   <= w_cs_s;
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_din_s     = r_din_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_prev & w_cs_s;
    assign w_sclk_rise = ~r_sclk_prev & w_sclk_s;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;

    // A frame already open when reset releases must not be picked up: only arm once the
    // synchronizer holds real samples and cs_n has been seen high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else begin
            if (r_flush_cnt != FLUSH_DONE) begin
                r_flush_cnt <= r_flush_cnt + 2'd1;
            end else if (w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    for (genvar n = 0; n < 8; n++) begin : g_ch
        assign w_ch[n] = ch_data[12*n +: 12];
    end

    assign w_cfg_ok = (r_bit_cnt >= 4'd6);
    assign w_ch_sel = w_cfg_ok ? {r_cfg_sh[4], r_cfg_sh[3:2]} : {r_cfg[4], r_cfg[3:2]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_dout       <= 1'b0;
            r_cfg        <= CFG_RESET;
            r_cfg_sh     <= '0;
            r_result     <= '0;
            r_tx         <= '0;
            r_bit_cnt    <= '0;
            r_conv_cnt   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_perr       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_perr       <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_dout <= 1'b0;
                    if (w_cs_fall && r_armed) begin
                        r_state   <= SHIFT;
                        r_dout    <= r_result[11];
                        r_tx      <= r_result[10:0];
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // Frame end wins over any sclk edge landing in the same cycle.
                    if (w_cs_rise) begin
                        r_state      <= CONVERT;
                        r_busy       <= 1'b1;
                        r_conv_cnt   <= CNT_W'(CONV_CYCLES - 1);
                        r_dout       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_result     <= w_ch[w_ch_sel];
                        if (w_cfg_ok) begin
                            r_cfg <= r_cfg_sh;
                        end else begin
                            r_perr <= 1'b1;
                        end
                    end else begin
                        if (w_sclk_rise) begin
                            if (r_bit_cnt < 4'd6) begin
                                r_cfg_sh[3'd5 - r_bit_cnt[2:0]] <= w_din_s;
                            end
                            if (r_bit_cnt != 4'd15) begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                        if (w_sclk_fall) begin
                            r_dout <= r_tx[10];
                            r_tx   <= {r_tx[9:0], 1'b0};
                        end
                    end
                end
                CONVERT: begin
                    r_dout <= 1'b0;
                    if (w_cs_fall) begin
                        r_perr <= 1'b1;
                    end
                    if (r_conv_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_conv_cnt <= r_conv_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_dout       = r_dout;
    assign cfg_word       = r_cfg;
    assign frame_done     = r_frame_done;
    assign protocol_error = r_perr;
    assign busy           = r_busy;

endmodule

// File: tb/tb_adc_2308_responder.sv
// Self-checking bench for adc_2308_responder: directed scenarios plus randomized
// frames, compared against a frame-level model of the ADC protocol.
module tb_adc_2308_responder;

    localparam int         CONV_CYCLES = 64;
    localparam int         SYNC_STAGES = 2;
    localparam int         HALF        = 8;
    localparam logic [5:0] CFG_RESET   = 6'b100010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic        adc_dout;
    logic [95:0] ch_data;
    logic [5:0]  cfg_word;
    logic        frame_done;
    logic        protocol_error;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    int pe_cnt  = 0;
    int both_cnt = 0;
    int busy_cnt = 0;
    int bc_mark  = 0;

    logic [5:0]  m_cfg;
    logic [11:0] m_result;

    adc_2308_responder #(
        .CONV_CYCLES(CONV_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .adc_cs_n(adc_cs_n),
        .adc_sclk(adc_sclk),
        .adc_din(adc_din),
        .adc_dout(adc_dout),
        .ch_data(ch_data),
        .cfg_word(cfg_word),
        .frame_done(frame_done),
        .protocol_error(protocol_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (protocol_error === 1'b1) pe_cnt++;
        if (frame_done === 1'b1 && protocol_error === 1'b1) both_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // Channel is {O/S, S1, S0} read as an unsigned 3-bit number.
    function automatic logic [11:0] ref_sample(input logic [95:0] data, input logic [5:0] cfg);
        int ch;
        ch = (cfg[4] ? 4 : 0) + (cfg[3] ? 2 : 0) + (cfg[2] ? 1 : 0);
        return data[ch*12 +: 12];
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_bits(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_frame(input logic [5:0] cfg_bits, input int nbits,
                             input bit expect_busy, input string name);
        int          fd0, pe0, both0;
        logic        exp_bit;
        bit          exp_perr;
        logic [11:0] snap;
        snap  = m_result;
        fd0   = fd_cnt;
        pe0   = pe_cnt;
        both0 = both_cnt;
        adc_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            adc_din = (i < 6) ? cfg_bits[5-i] : 1'($urandom);
            repeat (HALF) @(negedge clk);
            exp_bit = (expect_busy || i >= 12) ? 1'b0 : snap[11-i];
            check_bits($sformatf("%s dout bit %0d", name, i), {11'd0, adc_dout}, {11'd0, exp_bit});
            adc_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            adc_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (!expect_busy) bc_mark = busy_cnt;
        adc_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        if (!expect_busy) begin
            if (nbits >= 6) m_cfg = cfg_bits;
            exp_perr = (nbits < 6);
            m_result = ref_sample(ch_data, m_cfg);
        end else begin
            exp_perr = 1'b1;
        end
        check_int({name, " frame_done pulses"}, fd_cnt - fd0, expect_busy ? 0 : 1);
        check_int({name, " protocol_error pulses"}, pe_cnt - pe0, exp_perr ? 1 : 0);
        check_int({name, " error with frame_done"}, both_cnt - both0,
                  (!expect_busy && nbits < 6) ? 1 : 0);
        check_bits({name, " cfg_word"}, {6'd0, cfg_word}, {6'd0, m_cfg});
        if (!expect_busy) check_int({name, " busy after frame"}, int'(busy), 1);
    endtask

    task automatic gap(input int cycles, input bit check_busy, input string name);
        repeat (cycles) @(negedge clk);
        if (check_busy) begin
            check_int({name, " busy cycles"}, busy_cnt - bc_mark, CONV_CYCLES);
            check_int({name, " busy cleared"}, int'(busy), 0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_int({name, " dout"}, int'(adc_dout), 0);
        check_bits({name, " cfg_word"}, {6'd0, cfg_word}, {6'd0, CFG_RESET});
        check_int({name, " busy"}, int'(busy), 0);
        check_int({name, " frame_done"}, int'(frame_done), 0);
        check_int({name, " protocol_error"}, int'(protocol_error), 0);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        adc_cs_n = 1'b1;
        adc_sclk = 1'b0;
        adc_din  = 1'b0;
        ch_data  = '0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        m_cfg    = CFG_RESET;
        m_result = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_first_frames();
        ch_data = {$urandom, $urandom, $urandom};
        ch_data[11:0] = 12'hABC;
        run_frame(6'b100010, 12, 1'b0, "first");
        gap(80, 1'b1, "first");
        run_frame(6'b100010, 12, 1'b0, "second");
        gap(80, 1'b1, "second");
    endtask

    task automatic test_config_channel();
        ch_data = {$urandom, $urandom, $urandom};
        ch_data[36 +: 12] = 12'h5A5;
        ch_data[72 +: 12] = 12'h5A5;
        run_frame(6'b111010, 12, 1'b0, "cfg");
        gap(80, 1'b1, "cfg");
        run_frame(6'b111010, 12, 1'b0, "cfg_read");
        gap(80, 1'b1, "cfg_read");
    endtask

    task automatic test_short_frame();
        ch_data[72 +: 12] = 12'h3C7;
        ch_data[0 +: 12]  = 12'h111;
        run_frame(6'b000000, 4, 1'b0, "short");
        gap(80, 1'b1, "short");
        run_frame(6'b111010, 12, 1'b0, "short_read");
        gap(80, 1'b1, "short_read");
    endtask

    task automatic test_busy_overlap();
        ch_data = {$urandom, $urandom, $urandom};
        run_frame(6'b100010, 12, 1'b0, "pre_busy");
        gap(4, 1'b0, "pre_busy");
        run_frame(6'($urandom), 12, 1'b1, "busy");
        gap(80, 1'b1, "busy");
        ch_data = {$urandom, $urandom, $urandom};
        run_frame(6'b100010, 12, 1'b0, "after_busy");
        gap(80, 1'b1, "after_busy");
    endtask

    task automatic test_long_frame();
        ch_data = {$urandom, $urandom, $urandom};
        run_frame(6'b101110, 16, 1'b0, "long");
        gap(80, 1'b1, "long");
        run_frame(6'b100010, 16, 1'b0, "long_read");
        gap(80, 1'b1, "long_read");
    endtask

    task automatic test_reset_mid_frame();
        int         fd0, pe0;
        logic [5:0] cfg_bits;
        cfg_bits = 6'($urandom);
        adc_cs_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            adc_din = cfg_bits[5-i];
            repeat (HALF) @(negedge clk);
            adc_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            adc_sclk = 1'b0;
        end
        adc_din = 1'($urandom);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset");
        fd0 = fd_cnt;
        pe0 = pe_cnt;
        reset_n  = 1'b1;
        m_cfg    = CFG_RESET;
        m_result = '0;
        for (int i = 6; i < 12; i++) begin
            repeat (HALF) @(negedge clk);
            check_int($sformatf("mid_reset dout bit %0d", i), int'(adc_dout), 0);
            adc_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            adc_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        adc_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check_int("mid_reset frame_done", fd_cnt - fd0, 0);
        check_int("mid_reset protocol_error", pe_cnt - pe0, 0);
        check_bits("mid_reset cfg_word", {6'd0, cfg_word}, {6'd0, CFG_RESET});
        gap(80, 1'b0, "mid_reset");
        check_int("mid_reset busy", int'(busy), 0);
        ch_data = {$urandom, $urandom, $urandom};
        run_frame(6'($urandom), 12, 1'b0, "post_reset");
        gap(80, 1'b1, "post_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            ch_data = {$urandom, $urandom, $urandom};
            run_frame(6'($urandom), $urandom_range(3, 16), 1'b0, $sformatf("rand%0d", k));
            gap(80, 1'b1, $sformatf("rand%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_first_frames();
        test_config_channel();
        test_short_frame();
        test_busy_overlap();
        test_long_frame();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
